// File: rtl/mult_share_ctrl_if.sv
// Request/response bundle between the requesters, the result consumer and the shared-multiplier controller.
// The master modport is the client side; the slave modport is the controller side.
interface mult_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [63:0]          resp_product;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, busy
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one combinational 32x32 multiplier among NREQ requesters.
// Operands are registered at grant; the product is captured after a MUL_LAT settle window.
module multiplier_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] product_o
);
    assign product_o = {32'd0, a_i} * {32'd0, b_i};
endmodule

module mult_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2
) (
    input logic               clk,
    input logic               rst_n,
    mult_share_ctrl_if.slave  bus
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [63:0]     resp_product_q, resp_product_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand;
    logic [NREQ-1:0] grant_vec;
    logic [63:0]     mul_p;

    multiplier_32 u_mul (
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .product_o (mul_p)
    );

    // Search starts just after the previous winner, so simultaneous requests rotate.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_product_d = resp_product_q;
        grant_vec      = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    // Gating with rst_n keeps req_ready low while reset is held.
                    grant_vec[grant_idx] = rst_n;
                    op_a_d       = bus.req_a[32*grant_idx +: 32];
                    op_b_d       = bus.req_b[32*grant_idx +: 32];
                    resp_id_d    = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = CW'(MUL_LAT - 1);
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    resp_product_d = mul_p;
                    resp_valid_d   = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                // Returning to IDLE first leaves a one-cycle bubble before the next grant.
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= IDW'(NREQ - 1);
            cnt_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_product_q <= resp_product_d;
        end
    end

    assign bus.req_ready    = grant_vec;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: vector table, directed corner sequences,
// and a randomized run against a cycle-timestamp reference model.
module tb_mult_share_ctrl;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_ctrl_if #(.NREQ(N), .IDW(IDW)) bus  ();
    mult_share_ctrl_if #(.NREQ(N), .IDW(IDW)) bus1 ();

    mult_share_ctrl #(.NREQ(N), .IDW(IDW), .MUL_LAT(LAT)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    mult_share_ctrl #(.NREQ(N), .IDW(IDW), .MUL_LAT(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(bus.req_ready),  64'(0));
        chk({tag, "_busy"},       64'(bus.busy),       64'(0));
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
        chk({tag, "_resp_id"},    64'(bus.resp_id),    64'(0));
        chk({tag, "_product"},    bus.resp_product,    64'(0));
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released and no requests.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid  = '1;
        bus1.req_valid = '1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid  = '0;
        bus1.req_valid = '0;
    endtask

    task automatic drain();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 20 && bus.busy; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_idle", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
    endtask

    // One isolated request with full latency checks; DUT must be idle on entry.
    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] prod);
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", 64'(bus.req_ready), 64'(1) << id);
        chk("single_idle_busy", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk("single_calc_busy", 64'(bus.busy), 64'(1));
            chk("single_calc_no_resp", 64'(bus.resp_valid), 64'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("single_resp_valid", 64'(bus.resp_valid), 64'(1));
        chk("single_resp_id", 64'(bus.resp_id), 64'(id));
        chk("single_product", bus.resp_product, prod);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_done_busy", 64'(bus.busy), 64'(0));
        chk("single_done_valid", 64'(bus.resp_valid), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int gids[$];
        int gcyc[$];
        int m_last, m_active, m_t0, m_id, w;
        logic [63:0] m_prod;
        logic [N-1:0] exp_ready;
        logic exp_rv, exp_busy;

        vecs[0] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{1, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
        vecs[2] = '{2, 32'h0000_0001, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[3] = '{3, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[4] = '{1, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
        bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.resp_ready = 1'b1;

        do_reset();

        for (int i = 0; i < 5; i++) begin
            single_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].prod);
            $display("vector %0d: id=%0d a=0x%h b=0x%h", i, vecs[i].id, vecs[i].a, vecs[i].b);
        end

        // MUL_LAT=1 instance: response must appear in cycle 2
        bus1.req_valid = 4'b0001;
        bus1.req_a[31:0] = 32'h1;
        bus1.req_b[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lat1_grant", 64'(bus1.req_ready), 64'(1));
        @(posedge clk); #1;
        bus1.req_valid = '0;
        @(negedge clk);
        chk("lat1_c1_no_resp", 64'(bus1.resp_valid), 64'(0));
        chk("lat1_c1_busy", 64'(bus1.busy), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1_c2_resp", 64'(bus1.resp_valid), 64'(1));
        chk("lat1_c2_product", bus1.resp_product, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1_c3_idle", 64'(bus1.busy), 64'(0));
        @(posedge clk); #1;
        $display("lat1: single op done");

        // Fairness: everyone valid, grants rotate 0,1,2,3 four cycles apart
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*32 +: 32] = 32'(i + 1);
            bus.req_b[i*32 +: 32] = 32'h10;
        end
        bus.req_valid = '1;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 40 && gids.size() < 8; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                gids.push_back(onehot_idx(bus.req_ready));
                gcyc.push_back(c);
            end
            if (bus.resp_valid) begin
                if (gids.size() == 0) begin
                    chk("fair_resp_without_grant", 64'(bus.resp_valid), 64'(0));
                end else begin
                    chk("fair_id", 64'(bus.resp_id), 64'(gids[gids.size()-1]));
                    chk("fair_product", bus.resp_product, 64'((gids[gids.size()-1] + 1) * 16));
                end
            end
            @(posedge clk); #1;
        end
        chk("fair_grant_count", 64'(gids.size()), 64'(8));
        for (int k = 0; k < gids.size(); k++) begin
            chk("fair_order", 64'(gids[k]), 64'(k % N));
            if (k > 0) chk("fair_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(LAT + 2));
            $display("fairness grant %0d -> requester %0d at cycle %0d", k, gids[k], gcyc[k]);
        end
        drain();

        // Rotation: after requester 2, with only 1 and 3 valid, 3 wins first
        do_reset();
        single_op(2, 32'd3, 32'd4, 64'd12);
        gids.delete();
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 20 && gids.size() < 2; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) gids.push_back(onehot_idx(bus.req_ready));
            @(posedge clk); #1;
        end
        chk("rot_grant_count", 64'(gids.size()), 64'(2));
        if (gids.size() == 2) begin
            chk("rot_first", 64'(gids[0]), 64'(3));
            chk("rot_second", 64'(gids[1]), 64'(1));
            $display("rotation grants: %0d then %0d", gids[0], gids[1]);
        end
        drain();

        // Backpressure: response held 5 cycles, no grants while held
        bus.req_valid = 4'b0010;
        bus.req_a[63:32] = 32'h8000_0000;
        bus.req_b[63:32] = 32'h2;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        bus.req_valid = '1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk("bp_calc_no_ready", 64'(bus.req_ready), 64'(0));
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.resp_valid), 64'(1));
            chk("bp_hold_product", bus.resp_product, 64'h0000_0001_0000_0000);
            chk("bp_hold_id", 64'(bus.resp_id), 64'(1));
            chk("bp_hold_no_ready", 64'(bus.req_ready), 64'(0));
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.resp_valid), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_valid", 64'(bus.resp_valid), 64'(0));
        chk("bp_after_busy", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        $display("backpressure: held 5 cycles then released");

        // Reset mid-CALC: operation discarded, arbitration restarts at 0
        bus.req_valid = 4'b0100;
        bus.req_a[95:64] = 32'd5;
        bus.req_b[95:64] = 32'd7;
        bus.req_a[31:0]  = 32'd9;
        bus.req_b[31:0]  = 32'd9;
        @(negedge clk);
        chk("rstmid_grant", 64'(bus.req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        check_reset_outputs("rstmid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid_no_resp", 64'(bus.resp_valid), 64'(0));
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_next_grant", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                chk("rstmid_resp_id", 64'(bus.resp_id), 64'(0));
                chk("rstmid_resp_product", bus.resp_product, 64'd81);
            end
            @(posedge clk); #1;
        end
        drain();
        $display("reset mid-CALC: next grant to requester 0");

        // Randomized run against a timestamp-based reference model
        do_reset();
        m_last = N - 1; m_active = 0; m_t0 = 0; m_id = 0; m_prod = '0;
        for (int t = 0; t < 400; t++) begin
            bus.req_valid  = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) bus.req_valid = '0;
            for (int i = 0; i < N; i++) begin
                bus.req_a[i*32 +: 32] = $urandom();
                bus.req_b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);

            w = -1;
            if (!m_active) begin
                w = rr_winner(bus.req_valid, m_last);
                exp_ready = (w >= 0) ? N'(1 << w) : '0;
                exp_rv    = 1'b0;
                exp_busy  = 1'b0;
            end else begin
                exp_ready = '0;
                exp_rv    = ((t - m_t0) >= LAT + 1);
                exp_busy  = 1'b1;
            end

            @(negedge clk);
            chk("rand_req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rand_busy", 64'(bus.busy), 64'(exp_busy));
            chk("rand_resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("rand_resp_id", 64'(bus.resp_id), 64'(m_id));
                chk("rand_product", bus.resp_product, m_prod);
            end

            if (!m_active && w >= 0) begin
                m_active = 1; m_t0 = t; m_last = w; m_id = w;
                m_prod = {32'd0, bus.req_a[w*32 +: 32]} * {32'd0, bus.req_b[w*32 +: 32]};
                $display("rand t=%0d grant requester %0d", t, w);
            end else if (m_active && exp_rv && bus.resp_ready) begin
                m_active = 0;
                $display("rand t=%0d response id=%0d product=0x%h", t, m_id, m_prod);
            end
            @(posedge clk); #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing and arbitration controller that shares one combinational `multiplier_32` instance among `NREQ` requesters. It round-robin arbitrates valid/ready operand requests and registers the operands feeding the multiplier. It waits a fixed `MUL_LAT` settle window, then registers the 64-bit product and returns it on a single response channel tagged with the requester ID. It sits between the issue ports of client blocks and the shared multiplier datapath, and instantiates that datapath internally.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, width of the requester ID; must equal ceil(log2(`NREQ`))
- `MUL_LAT`, 2, cycles allotted for the multiplier to settle after operands are registered (>=1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  `NREQ`  per-requester request valid
- `req_ready`  out  `NREQ`  per-requester grant/accept; at most one bit high
- `req_a`  in  32*`NREQ`  operand A; requester i occupies bits [32i+31:32i]
- `req_b`  in  32*`NREQ`  operand B; same packing as `req_a`
- `resp_valid`  out  1  product available
- `resp_ready`  in  1  consumer accepts product
- `resp_id`  out  `IDW`  index of the requester that owns the product
- `resp_product`  out  64  unsigned `A*B`
- `busy`  out  1  high in CALC or RESP

## Operation
- Arithmetic: unsigned 32x32 -> 64, full width, no truncation or saturation. Operands come only from the internal `op_a`/`op_b` registers, never directly from request ports.
- State machine has three states: IDLE, CALC, RESP.
- IDLE:
  - Winner g is the first index with `req_valid` high, searching from (`last_grant`+1) mod `NREQ` upward with wrap.
  - `req_ready[g]` = 1 combinationally in the same cycle. All other `req_ready` bits are 0.
  - On the handshake, latch `op_a`, `op_b`, `resp_id`<=g and `last_grant`<=g, load `cnt`<=`MUL_LAT`-1, and go to CALC.
  - With no valid request, stay in IDLE.
- CALC:
  - `req_ready` = 0.
  - If `cnt`==0, capture the multiplier output into `resp_product`, set `resp_valid`, and go to RESP. Otherwise decrement `cnt`.
- RESP:
  - `resp_valid` = 1, and `resp_product`/`resp_id` are held stable.
  - On `resp_valid`&`resp_ready`, clear `resp_valid` and go to IDLE. No grant is issued in the same cycle; the bubble is required.
- `busy` = (state != IDLE).
- Requesters must not make `req_valid` depend on `req_ready`. A requester may drop `req_valid` without a handshake, and that request is simply not served.
- A requester that keeps `req_valid` high after its handshake is treated as a new request and competes normally.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state=IDLE, `last_grant`=`NREQ`-1 (requester 0 has first priority), `cnt`=0
  - `resp_valid`=0, `resp_id`=0, `resp_product`=0, `op_a`=`op_b`=0, `busy`=0, `req_ready`=0
- Latency, with the handshake in cycle 0:
  - CALC occupies cycles 1..`MUL_LAT`.
  - `resp_valid` rises in cycle `MUL_LAT`+1; this is cycle 3 at the default.
- Throughput: with `resp_ready` held high, one operation per `MUL_LAT`+2 cycles; the next grant can occur in cycle `MUL_LAT`+2.
- Backpressure: `resp_ready` low in RESP holds the response indefinitely. No new grants occur while held.
- Reset mid-operation (CALC or RESP): the operation is discarded and no response is produced. After `rst_n` deasserts, arbitration restarts at requester 0.
- Simultaneous requests are resolved only by round-robin order, never by index priority beyond the rotation.

## Test plan
- Single request: requester 0 sends A=0xFFFFFFFF, B=0xFFFFFFFF with `resp_ready`=1. Required: `req_ready[0]` high in cycle 0; `resp_valid` high in cycle 3 with product 0xFFFFFFFE00000001 and `resp_id`=0; `busy` low again in cycle 4.
- Fairness: all four requesters hold valid continuously, requester i sending A=i+1, B=0x10. Required: grants in order 0,1,2,3,0,..., four cycles apart, with products 0x10, 0x20, 0x30, 0x40 tagged with matching IDs.
- Rotation: after a grant to requester 2, only requesters 1 and 3 are valid. Required: 3 is granted first, then 1.
- Backpressure: hold `resp_ready` low for 5 cycles during RESP for 0x80000000*2. Required: `resp_product`=0x0000000100000000 stable throughout; all `req_ready` bits stay 0; release occurs on the first cycle `resp_ready` is high.
- Reset mid-CALC: assert `rst_n` low in cycle 1 after a grant. Required: all outputs return to reset values immediately; no `resp_valid` appears; the next grant goes to requester 0.
- Zero and identity operands: 0x0*0xDEADBEEF -> 0; 0x1*0xDEADBEEF -> 0x00000000DEADBEEF. Also run with `MUL_LAT`=1, which must produce the response in cycle 2.
